// File: rtl/dvp_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// dvp_pattern_gen_if
// ----------------------------------------------------------------------------
// DVP camera bus as seen between a sensor (or its stand-in) and the capture
// path.
//   VSYNC      : frame sync, low during the sync lines
//   HREF       : line valid, high while D carries pixel bytes
//   D[7:0]     : pixel byte, RGB565 high byte first
//   frame_done : one-cycle pulse on the last cycle of a frame
// Modports: master (transmitter side), slave (capture side).
// Revision: 1.0 - initial release
// ============================================================================
interface dvp_pattern_gen_if;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] D;
  logic       frame_done;

  modport master (output VSYNC, output HREF, output D, output frame_done);
  modport slave  (input  VSYNC, input  HREF, input  D, input  frame_done);
endinterface
`default_nettype wire

// File: rtl/dvp_pattern_gen.sv
`default_nettype none
// ============================================================================
// dvp_pattern_gen
// ----------------------------------------------------------------------------
// Synthetic OV2640-style DVP transmitter. Produces VSYNC/HREF timing and an
// RGB565 byte stream (high byte first) carrying a selectable test pattern,
// used in place of the sensor to drive the capture path.
// Ports:
//   PCLK        : byte clock
//   n_rst       : asynchronous active-low reset
//   enable      : run frames, sampled only at frame boundaries
//   pattern_sel : 0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid colour
//   solid_rgb   : RGB565 value for pattern 3
//   frame_cnt   : completed-frame counter (only with DVP_GEN_FRAME_CNT_EN)
//   bus         : DVP bus (VSYNC, HREF, D, frame_done), master side
// Optional feature macro: DVP_GEN_FRAME_CNT_EN adds frame_cnt and stamps
// its value into pixel (0,0) of each frame.
// Revision: 1.0 - initial release
// ============================================================================
module dvp_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10
) (
  input  wire logic        PCLK,
  input  wire logic        n_rst,
  input  wire logic        enable,
  input  wire logic [1:0]  pattern_sel,
  input  wire logic [15:0] solid_rgb,
`ifdef DVP_GEN_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  dvp_pattern_gen_if.master bus
);

  localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int TOTAL_LINES = VS_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW          = $clog2(LINE_LEN);
  localparam int VW          = (TOTAL_LINES > 1) ? $clog2(TOTAL_LINES) : 1;
  localparam int BAR_W       = H_ACTIVE / 8;
  localparam logic [HW-1:0] H_LAST      = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_ACT_BYTES = HW'(2 * H_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_BACK   = 3'd2,
    S_ACTIVE = 3'd3,
    S_FRONT  = 3'd4
  } state_t;

  state_t        state;
  logic [HW-1:0] h;
  logic [VW-1:0] v;       // line index within the current region
  logic [1:0]    pat;     // pattern_sel latched at SYNC entry
  logic [15:0]   solid;   // solid_rgb latched at SYNC entry

  logic [VW-1:0] v_last;
  logic          line_end;
  logic          region_end;
  logic          frame_end;
  logic          href_next;
  logic [15:0]   x;
  logic [2:0]    bar;
  logic          y4;
  logic [15:0]   pixel;
  logic [7:0]    byte_out;

  // Last line index of the region the FSM is currently in.
  always_comb begin
    v_last = '0;
    case (state)
      S_SYNC:   v_last = VW'(VS_LINES - 1);
      S_BACK:   v_last = VW'(V_BACK - 1);
      S_ACTIVE: v_last = VW'(V_ACTIVE - 1);
      S_FRONT:  v_last = VW'(V_FRONT - 1);
      default:  v_last = '0;
    endcase
  end

  assign line_end   = (h == H_LAST);
  assign region_end = line_end && (v == v_last);
  assign frame_end  = (state == S_FRONT) && region_end;
  assign href_next  = (state == S_ACTIVE) && (h < H_ACT_BYTES);

  assign x   = 16'(h) >> 1;
  assign bar = 3'(x / 16'(BAR_W));

  // Checkerboard needs y[4]; small frames have no such bit.
  if (VW > 4) begin : g_y4
    assign y4 = v[4];
  end else begin : g_y4_zero
    assign y4 = 1'b0;
  end

`ifdef DVP_GEN_FRAME_CNT_EN
  logic [15:0] cnt_latched;
  logic [15:0] cnt_next;

  // When a frame ends back-to-back, the counter increments on the same edge
  // that re-enters SYNC, so the stamped value must be the incremented one.
  assign cnt_next = frame_end ? frame_cnt + 16'd1 : frame_cnt;
`endif

  always_comb begin
    pixel = 16'h0000;
    case (pat)
      2'd0: begin
        case (bar)
          3'd0:    pixel = 16'hFFFF;
          3'd1:    pixel = 16'hFFE0;
          3'd2:    pixel = 16'h07FF;
          3'd3:    pixel = 16'h07E0;
          3'd4:    pixel = 16'hF81F;
          3'd5:    pixel = 16'hF800;
          3'd6:    pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd1:    pixel = {x[7:3], x[7:2], x[7:3]};
      2'd2:    pixel = (x[4] ^ y4) ? 16'hFFFF : 16'h0000;
      default: pixel = solid;
    endcase
`ifdef DVP_GEN_FRAME_CNT_EN
    if ((v == '0) && (h[HW-1:1] == '0)) begin
      pixel = cnt_latched;
    end
`endif
  end

  assign byte_out = h[0] ? pixel[7:0] : pixel[15:8];

  always_ff @(posedge PCLK or negedge n_rst) begin
    if (!n_rst) begin
      state          <= S_IDLE;
      h              <= '0;
      v              <= '0;
      pat            <= 2'd0;
      solid          <= 16'h0000;
      bus.VSYNC      <= 1'b0;
      bus.HREF       <= 1'b0;
      bus.D          <= 8'h00;
      bus.frame_done <= 1'b0;
`ifdef DVP_GEN_FRAME_CNT_EN
      frame_cnt      <= 16'h0000;
      cnt_latched    <= 16'h0000;
`endif
    end else begin
      bus.VSYNC      <= (state != S_IDLE) && (state != S_SYNC);
      bus.HREF       <= href_next;
      bus.D          <= href_next ? byte_out : 8'h00;
      bus.frame_done <= frame_end;
`ifdef DVP_GEN_FRAME_CNT_EN
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
`endif

      if (state == S_IDLE) begin
        h <= '0;
        v <= '0;
      end else if (line_end) begin
        h <= '0;
        v <= region_end ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (enable) begin
            state <= S_SYNC;
            pat   <= pattern_sel;
            solid <= solid_rgb;
`ifdef DVP_GEN_FRAME_CNT_EN
            cnt_latched <= cnt_next;
`endif
          end
        end
        S_SYNC:   if (region_end) state <= S_BACK;
        S_BACK:   if (region_end) state <= S_ACTIVE;
        S_ACTIVE: if (region_end) state <= S_FRONT;
        S_FRONT: begin
          if (region_end) begin
            if (enable) begin
              state <= S_SYNC;
              pat   <= pattern_sel;
              solid <= solid_rgb;
`ifdef DVP_GEN_FRAME_CNT_EN
              cnt_latched <= cnt_next;
`endif
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dvp_pattern_gen.sv
`default_nettype none
// ============================================================================
// tb_dvp_pattern_gen
// ----------------------------------------------------------------------------
// Self-checking bench for dvp_pattern_gen on a tiny 8x4 frame (L=20,
// frame=140 cycles). Expected pixel bytes are queued when a frame is started
// and popped while HREF is high; frame timing is captured relative to the
// edge that first samples enable.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dvp_pattern_gen;

  localparam int HA    = 8;
  localparam int VA    = 4;
  localparam int HB    = 4;
  localparam int VSL   = 1;
  localparam int VB    = 1;
  localparam int VF    = 1;
  localparam int FRAME = 140;

  logic        PCLK        = 1'b0;
  logic        n_rst       = 1'b0;
  logic        enable      = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb   = 16'h0000;
`ifdef DVP_GEN_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  dvp_pattern_gen_if bus ();

  dvp_pattern_gen #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_BLANK  (HB),
    .VS_LINES (VSL),
    .V_BACK   (VB),
    .V_FRONT  (VF)
  ) u_dut (
    .PCLK        (PCLK),
    .n_rst       (n_rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
`ifdef DVP_GEN_FRAME_CNT_EN
    .frame_cnt   (frame_cnt),
`endif
    .bus         (bus)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int f_start  = 0;
  int n_frames = 0;
  bit mon_on   = 1'b0;

  logic [7:0] exp_q[$];
  int         fd_q[$];
  int         vs_rise_k, vs_fall_k, href_rise_k, href_w, href_pulses;
  logic       prev_vs, prev_href;

  always @(posedge PCLK) cyc++;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] exp_pixel(input logic [1:0] pat, input logic [15:0] solid,
                                            input int x, input int y);
    logic [15:0] bars [8];
    logic [7:0]  xb;
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    xb = x[7:0];
    case (pat)
      2'd0:    return bars[x / (HA / 8)];
      2'd1:    return {xb[7:3], xb[7:2], xb[7:3]};
      2'd2:    return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return solid;
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] pat, input logic [15:0] solid, input int fc);
    logic [15:0] px;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        px = exp_pixel(pat, solid, x, y);
`ifdef DVP_GEN_FRAME_CNT_EN
        if (x == 0 && y == 0) px = fc[15:0];
`endif
        exp_q.push_back(px[15:8]);
        exp_q.push_back(px[7:0]);
      end
    end
  endtask

  task automatic reset_stats();
    exp_q.delete();
    fd_q.delete();
    vs_rise_k   = -1;
    vs_fall_k   = -1;
    href_rise_k = -1;
    href_w      = -1;
    href_pulses = 0;
    prev_vs     = 1'b0;
    prev_href   = 1'b0;
  endtask

  // Monitor: k is the index of the most recent active edge since frame start.
  always @(negedge PCLK) begin : mon
    int k;
    if (mon_on) begin
      k = cyc - f_start - 1;
      if (bus.HREF) begin
        if (exp_q.size() == 0) check("extra_byte", int'(bus.D), -1);
        else                   check("d_byte", int'(bus.D), int'(exp_q.pop_front()));
      end else begin
        check("d_blank", int'(bus.D), 0);
      end
      if (bus.VSYNC && !prev_vs && vs_rise_k < 0) vs_rise_k = k;
      if (!bus.VSYNC && prev_vs && vs_fall_k < 0) vs_fall_k = k;
      if (bus.HREF && !prev_href) begin
        href_pulses++;
        if (href_rise_k < 0) href_rise_k = k;
      end
      if (!bus.HREF && prev_href && href_w < 0) href_w = k - href_rise_k;
      if (bus.frame_done) fd_q.push_back(k);
      prev_vs   = bus.VSYNC;
      prev_href = bus.HREF;
    end
  end

  task automatic begin_frame(input logic [1:0] pat, input logic [15:0] solid);
    @(negedge PCLK);
    #1;
    reset_stats();
    pattern_sel = pat;
    solid_rgb   = solid;
    enable      = 1'b1;
    f_start     = cyc;
    mon_on      = 1'b1;
  endtask

  task automatic wait_k(input int k);
    while (cyc - f_start - 1 < k) begin
      @(negedge PCLK);
      #1;
    end
  endtask

  task automatic check_common(input int frames, input int pulses);
    check("vsync_rise", vs_rise_k, (VSL * 20) + 1);
    check("vsync_fall", vs_fall_k, FRAME + 1);
    check("href_rise", href_rise_k, ((VSL + VB) * 20) + 1);
    check("href_width", href_w, 2 * HA);
    check("href_pulses", href_pulses, pulses);
    check("fd_count", fd_q.size(), frames);
    for (int i = 0; i < fd_q.size(); i++) check("fd_time", fd_q[i], FRAME * (i + 1));
    check("bytes_left", exp_q.size(), 0);
    check("vsync_idle", int'(bus.VSYNC), 0);
  endtask

  initial begin
    reset_stats();
    repeat (3) @(negedge PCLK);
    #1;
    check("rst_vsync", int'(bus.VSYNC), 0);
    check("rst_href", int'(bus.HREF), 0);
    check("rst_d", int'(bus.D), 0);
    check("rst_fd", int'(bus.frame_done), 0);
`ifdef DVP_GEN_FRAME_CNT_EN
    check("rst_frame_cnt", int'(frame_cnt), 0);
`endif
    n_rst = 1'b1;

    // Colour bars, enable dropped mid-frame: frame completes, then idle.
    begin_frame(2'd0, 16'h0000);
    push_frame(2'd0, 16'h0000, n_frames);
    wait_k(50);
    enable = 1'b0;
    wait_k(200);
    check_common(1, 4);
    n_frames += 1;

    // Solid colour, two back-to-back frames.
    begin_frame(2'd3, 16'h1234);
    push_frame(2'd3, 16'h1234, n_frames);
    push_frame(2'd3, 16'h1234, n_frames + 1);
    wait_k(150);
    enable = 1'b0;
    wait_k(300);
    check_common(2, 8);
    n_frames += 2;

    // Checkerboard, switched to bars during ACTIVE: takes effect next frame.
    begin_frame(2'd2, 16'h0000);
    push_frame(2'd2, 16'h0000, n_frames);
    push_frame(2'd0, 16'h0000, n_frames + 1);
    wait_k(50);
    pattern_sel = 2'd0;
    wait_k(150);
    enable = 1'b0;
    wait_k(300);
    check_common(2, 8);
    n_frames += 2;

    // Grey ramp; mid-frame changes of pattern and colour are ignored.
    begin_frame(2'd1, 16'hABCD);
    push_frame(2'd1, 16'hABCD, n_frames);
    wait_k(45);
    pattern_sel = 2'd3;
    solid_rgb   = 16'h5555;
    enable      = 1'b0;
    wait_k(200);
    check_common(1, 4);
    n_frames += 1;

    // Reset during ACTIVE: outputs drop at once, fresh frame after release.
    begin_frame(2'd0, 16'h0000);
    push_frame(2'd0, 16'h0000, n_frames);
    wait_k(45);
    check("pre_rst_href", int'(bus.HREF), 1);
    mon_on = 1'b0;
    n_rst  = 1'b0;
    #1;
    check("arst_href", int'(bus.HREF), 0);
    check("arst_d", int'(bus.D), 0);
    check("arst_vsync", int'(bus.VSYNC), 0);
    repeat (2) @(negedge PCLK);
    #1;
    reset_stats();
    n_frames = 0;
    push_frame(2'd0, 16'h0000, n_frames);
    f_start = cyc;
    n_rst   = 1'b1;
    mon_on  = 1'b1;
    wait_k(50);
    enable = 1'b0;
    wait_k(200);
    check_common(1, 4);

    // Three back-to-back frames from a clean reset (frame stamp when enabled).
    @(negedge PCLK);
    #1;
    n_rst = 1'b0;
    @(negedge PCLK);
    #1;
    n_rst    = 1'b1;
    n_frames = 0;
    begin_frame(2'd3, 16'hBEEF);
    push_frame(2'd3, 16'hBEEF, 0);
    push_frame(2'd3, 16'hBEEF, 1);
    push_frame(2'd3, 16'hBEEF, 2);
    wait_k(290);
    enable = 1'b0;
    wait_k(450);
    check_common(3, 12);
`ifdef DVP_GEN_FRAME_CNT_EN
    check("frame_cnt", int'(frame_cnt), 3);
`endif

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
